// File: rtl/accum_alu.sv
// Accumulator ALU with OFF/READY/RUN/ERROR control and an optional multi-cycle shift-add multiply.
// Define ACCUM_ALU_MUL_EN to build the multiplier; without it a MUL request reports an error.
module accum_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             err_clr,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_valid,
    output logic             error,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StOff   = 2'b00,
        StReady = 2'b01,
        StRun   = 2'b10,
        StError = 2'b11
    } stateE;

    localparam logic [2:0] OpMul = 3'b110;

    stateE            stateQ;
    logic [WIDTH-1:0] accQ;
    logic             outValidQ;

    logic [WIDTH-1:0] aluRes;
    logic             aluErr;
    logic [WIDTH:0]   addFull;
    logic [WIDTH:0]   subFull;

    // The extra top bit of each wide result is the carry-out / borrow.
    always_comb begin
        aluRes  = accQ;
        aluErr  = 1'b0;
        addFull = {1'b0, accQ} + {1'b0, operand};
        subFull = {1'b0, accQ} - {1'b0, operand};
        unique case (op)
            3'b000: aluRes = accQ & operand;
            3'b001: aluRes = accQ | operand;
            3'b010: aluRes = accQ ^ operand;
            3'b011: aluRes = ~accQ;
            3'b100: begin
                aluRes = addFull[WIDTH-1:0];
                aluErr = addFull[WIDTH];
            end
            3'b101: begin
                aluRes = subFull[WIDTH-1:0];
                aluErr = subFull[WIDTH];
            end
            3'b110: aluRes = accQ;
            3'b111: aluRes = '0;
        endcase
    end

`ifdef ACCUM_ALU_MUL_EN
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcandQ;
    logic [WIDTH-1:0]   mprQ;
    logic [2*WIDTH-1:0] prodQ;
    logic [CntW-1:0]    cntQ;
    logic [2*WIDTH-1:0] prodNext;

    assign prodNext = prodQ + (mprQ[0] ? mcandQ : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StOff;
            accQ      <= '0;
            outValidQ <= 1'b0;
`ifdef ACCUM_ALU_MUL_EN
            mcandQ    <= '0;
            mprQ      <= '0;
            prodQ     <= '0;
            cntQ      <= '0;
`endif
        end else if (!on) begin
            stateQ    <= StOff;
            accQ      <= '0;
            outValidQ <= 1'b0;
`ifdef ACCUM_ALU_MUL_EN
            mcandQ    <= '0;
            mprQ      <= '0;
            prodQ     <= '0;
            cntQ      <= '0;
`endif
        end else begin
            outValidQ <= 1'b0;
            case (stateQ)
                StOff: stateQ <= StReady;
                StReady: begin
                    if (in_valid) begin
                        if (load) begin
                            accQ      <= operand;
                            outValidQ <= 1'b1;
                        end else if (op == OpMul) begin
`ifdef ACCUM_ALU_MUL_EN
                            mcandQ <= {{WIDTH{1'b0}}, accQ};
                            mprQ   <= operand;
                            prodQ  <= '0;
                            cntQ   <= '0;
                            stateQ <= StRun;
`else
                            outValidQ <= 1'b1;
                            stateQ    <= StError;
`endif
                        end else begin
                            accQ      <= aluRes;
                            outValidQ <= 1'b1;
                            if (aluErr) begin
                                stateQ <= StError;
                            end
                        end
                    end
                end
                StRun: begin
`ifdef ACCUM_ALU_MUL_EN
                    // One multiplier bit per cycle; the last step commits the result.
                    prodQ  <= prodNext;
                    mcandQ <= mcandQ << 1;
                    mprQ   <= mprQ >> 1;
                    cntQ   <= cntQ + 1'b1;
                    if (cntQ == LastCnt) begin
                        accQ      <= prodNext[WIDTH-1:0];
                        outValidQ <= 1'b1;
                        cntQ      <= '0;
                        stateQ    <= (|prodNext[2*WIDTH-1:WIDTH]) ? StError : StReady;
                    end
`else
                    stateQ <= StReady;
`endif
                end
                StError: begin
                    if (err_clr) begin
                        stateQ <= StReady;
                    end
                end
            endcase
        end
    end

    assign acc_out   = accQ;
    assign out_valid = outValidQ;
    assign state     = stateQ;
    assign in_ready  = (stateQ == StReady);
    assign error     = (stateQ == StError);

endmodule

// File: doc/accum_alu.md
ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set datapath and accumulator width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 on  input  1  SHALL be the power enable; 0 forces state OFF.
REQ-005 in_valid  input  1  SHALL be the request strobe.
REQ-006 in_ready  output  1  SHALL be high only in READY; a transfer occurs when in_valid and in_ready are both high.
REQ-007 load  input  1  SHALL select accumulator load from operand; when high, op is ignored.
REQ-008 op  input  3  SHALL be the opcode: 000 AND, 001 OR, 010 XOR, 011 NOT(acc), 100 ADD, 101 SUB (acc-operand), 110 MUL, 111 CLR.
REQ-009 operand  input  WIDTH  SHALL be the second operand.
REQ-010 err_clr  input  1  SHALL be the error acknowledge.
REQ-011 acc_out  output  WIDTH  SHALL be the registered accumulator value.
REQ-012 out_valid  output  1  SHALL be a one-cycle pulse marking a new acc_out result.
REQ-013 error  output  1  SHALL be high while the state is ERROR.
REQ-014 state  output  2  SHALL be the current state: 00 OFF, 01 READY, 10 RUN, 11 ERROR.

Function
REQ-015 OFF SHALL go to READY on the first edge with on=1; in_ready=0 while in OFF.
REQ-016 on=0 SHALL force OFF on the next edge from any state; it clears acc, aborts any MUL, and has priority over all other inputs.
REQ-017 A READY transfer with load=1 SHALL set acc to operand on the transfer edge, pulse out_valid in the following cycle, and stay in READY.
REQ-018 A READY transfer with ops 000-101 or 111 SHALL write the WIDTH-bit truncated result to acc on the transfer edge and pulse out_valid in the following cycle.
REQ-019 ADD carry-out or SUB borrow SHALL still write the truncated result, pulse out_valid, and move the state to ERROR.
REQ-020 A MUL transfer SHALL enter RUN, hold in_ready=0, and run a shift-add multiply for exactly WIDTH cycles; acc and out_valid SHALL update on the WIDTH-th edge after the transfer edge, and the state SHALL return to READY on that edge.
REQ-021 A MUL whose 2*WIDTH product has nonzero upper WIDTH bits SHALL write the low WIDTH bits and go to ERROR instead of READY.
REQ-022 ERROR SHALL hold acc, keep in_ready=0, and go to READY on the edge where err_clr=1; err_clr outside ERROR SHALL be ignored.
REQ-023 In RUN, in_valid, load and op SHALL be ignored; the operands SHALL be captured at the transfer edge.
REQ-024 out_valid SHALL never be high for two consecutive cycles from a single transfer.

Reset
REQ-025 When rst_n=0, the block SHALL immediately set state=OFF, acc_out=0, out_valid=0, error=0 and in_ready=0, and clear the multiplier counter and partial product.
REQ-026 Deasserting rst_n mid-MUL SHALL leave no residual result; the first transfer after reset SHALL behave as if issued from power-up.

Configuration
REQ-027 Macro ACCUM_ALU_MUL_EN defined: the MUL datapath and RUN state SHALL be implemented as specified in REQ-020 and REQ-021.
REQ-028 Macro ACCUM_ALU_MUL_EN undefined: the multiplier SHALL be absent, state 10 SHALL be unreachable, and a MUL transfer SHALL leave acc unchanged, pulse out_valid, and go to ERROR.

Verification
REQ-029 WIDTH=8; reset, on=1, load 0x0F, then ADD 0x01 -> acc_out=0x10 and out_valid pulses one cycle after each transfer, state=01.
REQ-030 acc=0xFF, ADD 0x01 -> acc_out=0x00, state=11, error=1; err_clr pulse -> state=01, error=0.
REQ-031 MUL_EN defined; acc=0x0C, MUL 0x0A -> in_ready=0 for 8 cycles, then acc_out=0x78, state=01; acc=0x20, MUL 0x10 -> acc_out=0x00, state=11.
REQ-032 MUL in progress, on=0 at cycle 3 -> state=00 and acc_out=0 on the next edge, with no out_valid.
REQ-033 rst_n pulled low mid-MUL -> all outputs zero immediately; after on=1 and load 0x05 -> acc_out=0x05.
REQ-034 MUL_EN undefined; acc=0x03, MUL 0x02 -> acc_out stays 0x03, state=11, and state 10 is never observed.
